// File: rtl/nyan_keys_pkg.sv
// Shared definitions for the keyboard front-end: key count, code width
// and the layout of a single press/release event.
package nyan_keys_pkg;

    localparam int KEYS_DEFAULT = 61;
    localparam int KEY_CODE_W   = $clog2(KEYS_DEFAULT);

    // Event word as it travels through the event FIFO: press flag on top,
    // key index below.
    typedef struct packed {
        logic                  press;
        logic [KEY_CODE_W-1:0] code;
    } key_event_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head word is visible on
// rd_data whenever the FIFO is not empty; a pop simply advances the head.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop needs data present; a push into a full FIFO is allowed only
    // when the head is leaving on the same edge.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset; the head is masked to zero while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop
    // leaves the occupancy unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_encoder.sv
// Turns the debounced key-level vector into a stream of press/release
// events. A round-robin scanner visits one key per clock, compares it with
// the level last reported for that key and queues an event on a change.
// When the event FIFO cannot take the event the scanner waits on that key.
module key_event_encoder
    import nyan_keys_pkg::*;
#(
    parameter int KEYS       = KEYS_DEFAULT,
    parameter int FIFO_DEPTH = 16,
    parameter int CODE_W     = $clog2(KEYS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [KEYS-1:0]               keys_i,
    output logic                          event_valid_o,
    input  logic                          event_ready_i,
    output logic [CODE_W-1:0]             event_code_o,
    output logic                          event_press_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int                EV_W     = CODE_W + 1;
    localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(KEYS - 1);

    logic [KEYS-1:0]   reported;
    logic [CODE_W-1:0] scan_idx;
    logic              cur_level;
    logic              mismatch;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              advance;
    logic [EV_W-1:0]   push_data;
    logic [EV_W-1:0]   head_data;

    // Decide whether the key under the scanner produces an event this cycle
    // and whether the scanner may move on.
    always_comb begin
        cur_level = keys_i[scan_idx];
        mismatch  = (cur_level != reported[scan_idx]);
        pop       = !fifo_empty && event_ready_i;
        push      = mismatch && (!fifo_full || pop);
        advance   = !mismatch || push;
        push_data = {cur_level, scan_idx};
    end

    // Scanner position and per-key reported level; the reported level only
    // changes when its event actually enters the FIFO, so nothing is lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scan_idx <= '0;
            reported <= '0;
        end else begin
            if (advance) begin
                scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + CODE_W'(1);
            end
            if (push) begin
                reported[scan_idx] <= cur_level;
            end
        end
    end

    sync_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (push),
        .wr_data (push_data),
        .pop     (pop),
        .rd_data (head_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_o)
    );

    assign event_valid_o                 = !fifo_empty;
    assign {event_press_o, event_code_o} = head_data;

endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench for key_event_encoder. A queue-based reference model
// tracks what the encoder should have reported and what sits in its FIFO;
// directed scenarios are followed by a randomized soak.
module tb_key_event_encoder;

    localparam int KEYS  = 61;
    localparam int DEPTH = 16;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic [KEYS-1:0]  keys_i = '0;
    logic             event_ready_i = 1'b0;
    logic             event_valid_o;
    logic [5:0]       event_code_o;
    logic             event_press_o;
    logic [4:0]       fifo_level_o;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        bit press;
        int code;
    } ev_t;

    ev_t model_q[$];
    bit  model_rep[KEYS];
    int  model_scan;

    key_event_encoder #(
        .KEYS       (KEYS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .keys_i        (keys_i),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .event_code_o  (event_code_o),
        .event_press_o (event_press_o),
        .fifo_level_o  (fifo_level_o)
    );

    // Free-running clock, period 10
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assert_count++;
        if (observed != expected) begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        foreach (model_rep[i]) model_rep[i] = 1'b0;
        model_scan = 0;
    endtask

    // One clock of the behavioural model using the inputs present at the edge
    task automatic modelStep();
        bit  can_pop;
        bit  can_push;
        ev_t ev;
        can_pop  = (model_q.size() != 0) && event_ready_i;
        can_push = (model_q.size() < DEPTH) || can_pop;
        if (can_pop) model_q.delete(0);
        if (keys_i[model_scan] != model_rep[model_scan]) begin
            if (can_push) begin
                ev.press = keys_i[model_scan];
                ev.code  = model_scan;
                model_q.push_back(ev);
                model_rep[model_scan] = keys_i[model_scan];
                model_scan = (model_scan + 1) % KEYS;
            end
        end else begin
            model_scan = (model_scan + 1) % KEYS;
        end
    endtask

    task automatic compareModel();
        checkOutput("valid", int'(event_valid_o), int'(model_q.size() != 0));
        checkOutput("level", int'(fifo_level_o), model_q.size());
        if (model_q.size() != 0) begin
            checkOutput("code", int'(event_code_o), model_q[0].code);
            checkOutput("press", int'(event_press_o), int'(model_q[0].press));
        end
    endtask

    // Hold the given inputs for a number of clocks, checking after every edge
    task automatic applyStimulus(input logic [KEYS-1:0] k, input bit r, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            keys_i        = k;
            event_ready_i = r;
            @(posedge clk_i);
            modelStep();
            #1;
            compareModel();
        end
    endtask

    // Asynchronous reset held across one clock edge
    task automatic doReset();
        rst_i = 1'b1;
        #2;
        modelReset();
        checkOutput("rst_valid", int'(event_valid_o), 0);
        checkOutput("rst_level", int'(fifo_level_o), 0);
        checkOutput("rst_code", int'(event_code_o), 0);
        checkOutput("rst_press", int'(event_press_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        logic [KEYS-1:0] k;
        logic [KEYS-1:0] rk;
        bit              rr;
        int              ready_bias;

        $display("[TB] key_event_encoder bench starting");
        #3;
        modelReset();
        doReset();

        // Idle: no keys, consumer ready, nothing ever appears
        applyStimulus('0, 1'b1, 200);
        checkOutput("idle_level", int'(fifo_level_o), 0);

        // Single key press seen six cycles after the scan starts at index 0
        doReset();
        k = '0;
        k[5] = 1'b1;
        applyStimulus(k, 1'b0, 5);
        checkOutput("key5_early", int'(event_valid_o), 0);
        applyStimulus(k, 1'b0, 1);
        checkOutput("key5_valid", int'(event_valid_o), 1);
        checkOutput("key5_code", int'(event_code_o), 5);
        checkOutput("key5_press", int'(event_press_o), 1);
        applyStimulus(k, 1'b1, 1);
        k[5] = 1'b0;
        applyStimulus(k, 1'b0, 70);
        checkOutput("key5_rel_level", int'(fifo_level_o), 1);
        checkOutput("key5_rel_code", int'(event_code_o), 5);
        checkOutput("key5_rel_press", int'(event_press_o), 0);
        applyStimulus(k, 1'b1, 3);

        // Keys 60 and 0 pressed while the scanner sits at 30: 60 comes first
        doReset();
        applyStimulus('0, 1'b0, 30);
        k = '0;
        k[60] = 1'b1;
        k[0]  = 1'b1;
        applyStimulus(k, 1'b0, 40);
        checkOutput("wrap_level", int'(fifo_level_o), 2);
        checkOutput("wrap_first", int'(event_code_o), 60);
        applyStimulus(k, 1'b1, 1);
        checkOutput("wrap_second", int'(event_code_o), 0);
        applyStimulus(k, 1'b1, 5);

        // Backpressure: 20 presses against a 16-deep FIFO
        doReset();
        k = '0;
        for (int i = 0; i < 20; i++) k[2*i+1] = 1'b1;
        applyStimulus(k, 1'b0, 80);
        checkOutput("full_level", int'(fifo_level_o), 16);
        checkOutput("full_head", int'(event_code_o), 1);
        applyStimulus(k, 1'b1, 1);
        checkOutput("full_pushpop_level", int'(fifo_level_o), 16);
        checkOutput("full_pushpop_head", int'(event_code_o), 3);
        applyStimulus(k, 1'b1, 80);
        checkOutput("drain_level", int'(fifo_level_o), 0);

        // Reset with events queued and keys still held
        doReset();
        k = '0;
        k[3] = 1'b1; k[10] = 1'b1; k[20] = 1'b1; k[40] = 1'b1; k[55] = 1'b1;
        applyStimulus(k, 1'b0, 70);
        checkOutput("queued_level", int'(fifo_level_o), 5);
        doReset();
        applyStimulus(k, 1'b0, 61);
        checkOutput("regen_level", int'(fifo_level_o), 5);
        checkOutput("regen_code", int'(event_code_o), 3);
        checkOutput("regen_press", int'(event_press_o), 1);

        // Randomized soak with varying consumer readiness and rare resets
        doReset();
        rk = '0;
        ready_bias = 3;
        for (int c = 0; c < 2000; c++) begin
            if (c % 250 == 0) ready_bias = $urandom_range(0, 4);
            if ($urandom_range(0, 2) == 0) rk[$urandom_range(0, KEYS-1)] ^= 1'b1;
            rr = ($urandom_range(0, 3) < ready_bias);
            if ($urandom_range(0, 699) == 0) begin
                keys_i = rk;
                doReset();
            end else begin
                applyStimulus(rk, rr, 1);
            end
        end
        applyStimulus(rk, 1'b1, 150);
        checkOutput("soak_drained", int'(fifo_level_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/key_event_encoder.md
# key_event_encoder

Converts the debounced key-state vector from the key debouncer into a serial stream of press/release events. A round-robin scanner compares each key's current state against the last state it reported, and pushes one event per detected change into a small FIFO. The FIFO is drained through a valid/ready handshake by the downstream USB HID/report builder. The block sits directly downstream of the debouncer and consumes its `keys_o` vector unchanged.

## Interface

- `KEYS`, default 61: number of key inputs.
- `FIFO_DEPTH`, default 16: event FIFO entries; must be a power of two, minimum 2.
- `CODE_W`, default `$clog2(KEYS)` (6 for 61): key-index width.

Clocking: one clock; reset is asynchronous and active-high.

- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `keys_i`, in, KEYS: debounced key levels; 1 = pressed; synchronous to `clk_i`.
- `event_valid_o`, out, 1: FIFO head holds an event.
- `event_ready_i`, in, 1: consumer accepts the head this cycle.
- `event_code_o`, out, CODE_W: key index of the head event.
- `event_press_o`, out, 1: 1 = press, 0 = release.
- `fifo_level_o`, out, `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation

- State held:
  - `reported[KEYS-1:0]`: last level emitted per key.
  - `scan_idx[CODE_W-1:0]`.
  - FIFO storage.
- Reset values:
  - `reported` = all 0 (all keys released, matching the debouncer's reset output).
  - `scan_idx` = 0.
  - FIFO empty.
  - Outputs: `event_valid_o`=0, `fifo_level_o`=0, `event_code_o`/`event_press_o`=0.
- Each cycle, the scanner examines key `k = scan_idx`. A mismatch exists when `keys_i[k] != reported[k]`.
- Mismatch, and the FIFO can accept a push (not full, or full with a pop in the same cycle):
  - push `{press=keys_i[k], code=k}`;
  - set `reported[k] <= keys_i[k]`;
  - advance `scan_idx`.
- Mismatch with the FIFO unable to accept: stall. `scan_idx` and `reported` hold, and nothing is dropped.
- No mismatch: advance `scan_idx` with no push.
- Advance wraps `KEYS-1 -> 0`. Index values `>= KEYS` are never produced.
- Events for a single key always alternate press/release, because `reported` toggles only on push.
- A key level that toggles twice between visits of the scanner produces no event. This is accepted behaviour: `reported` always converges to `keys_i`.
- The FIFO is first-word fall-through:
  - `event_valid_o = !empty`;
  - pop when `event_valid_o && event_ready_i`;
  - `event_code_o`/`event_press_o` are stable while `valid && !ready`.
- Simultaneous push and pop:
  - when full: permitted, level unchanged;
  - when empty: the pop is not possible (valid=0), so the level becomes 1.
- Asserting reset mid-operation clears all state asynchronously. Events pending in the FIFO are discarded.

## Timing

- Push occurs at the clock edge ending the cycle in which `scan_idx==k` with a mismatch. `event_valid_o` is high the following cycle, so event latency is 1 cycle after the scan hit.
- Worst-case detection latency from a `keys_i[k]` change to `event_valid_o` is KEYS cycles (61), plus any backpressure stall.
- One push per cycle maximum; sustained rate is 1 event per clock when the consumer is always ready.
- `fifo_level_o` updates on the same edge as push/pop.

## Structure

- Shared package `nyan_keys_pkg`:
  - `KEYS_DEFAULT`;
  - `key_event_t` packed struct `{logic press; logic [CODE_W-1:0] code;}`;
  - `KEY_CODE_W`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - single-clock, FWFT;
  - outputs `full`, `empty`, `level`;
  - same async active-high reset.
- The scanner and `reported` register stay in `key_event_encoder`.

## Test plan

- Reset, then drive `keys_i`=0 for 200 cycles with ready=1 -> `event_valid_o` never asserts; `fifo_level_o`=0.
- Set `keys_i[5]`=1 while `scan_idx`=0 -> exactly one event `{press=1, code=5}` is valid 6 cycles later. Clearing `keys_i[5]` then yields `{press=0, code=5}`.
- Set keys 60 and 0 in the same cycle while `scan_idx`=30 -> events are emitted in order code 60 then code 0, with no duplicates.
- Hold `event_ready_i`=0 and toggle 20 distinct keys -> level saturates at 16 and the scanner stalls on the 17th mismatch. Raise ready -> all 20 events arrive in scan order with correct polarity and none are lost.
- With the FIFO full, pop and push in the same cycle -> level stays 16 and the head advances correctly.
- Assert `rst_i` for 1 cycle with 5 events queued and keys held pressed -> FIFO empties immediately. Press events for the still-held keys are regenerated after reset, within 61 cycles.
